// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU submodule select, arithmetic op codes and the result-beat record
package alu_pkg;

  typedef enum logic [1:0] {
    ARITHMETIC = 2'd0,
    LOGIC      = 2'd1,
    LSHIFT     = 2'd2,
    RSHIFT     = 2'd3
  } alu_submodule_e;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] ADC = 2'b10;
  localparam logic [1:0] SBB = 2'b11;

  // Result word is sized for the widest supported datapath; users keep the low bit_width bits.
  localparam int ALU_W_MAX = 64;

  typedef struct packed {
    logic [ALU_W_MAX-1:0] r;
    logic                 last;
    logic                 cf;
    logic                 of;
    logic                 zf;
  } alu_beat_t;

endpackage

// File: rtl/alu_sequencer_alu.sv
// rtl/alu_sequencer_alu.sv - combinational ALU: arithmetic, logic, left and right shift slots
module ALU
  import alu_pkg::*;
#(
  parameter int bit_width = 4
) (
  input  alu_submodule_e       unit_i,
  input  logic [1:0]           op_i,
  input  logic [bit_width-1:0] a_i,
  input  logic [bit_width-1:0] b_i,
  input  logic                 cin_i,
  output logic [bit_width-1:0] r_o,
  output logic                 cf_o,
  output logic                 of_o,
  output logic                 zf_o
);

  localparam int SH_W = $clog2(bit_width);
  localparam int MSB  = bit_width - 1;

  logic [bit_width-1:0] ar_a, ar_b, lg_a, lg_b, sh_a;
  logic [SH_W-1:0]      sh_amt;
  logic [1:0]           ar_op, lg_op, sh_op;
  logic [bit_width:0]   ext_c, sum;
  logic [bit_width-1:0] lg_r, shl_r, shr_r;
  logic                 ar_of;

  // Only the selected slot sees live operands; the others idle at zero.
  always_comb begin
    ar_a = '0; ar_b = '0; ar_op = '0;
    lg_a = '0; lg_b = '0; lg_op = '0;
    sh_a = '0; sh_amt = '0; sh_op = '0;
    case (unit_i)
      ARITHMETIC: begin ar_a = a_i; ar_b = b_i; ar_op = op_i; end
      LOGIC:      begin lg_a = a_i; lg_b = b_i; lg_op = op_i; end
      default:    begin sh_a = a_i; sh_amt = b_i[SH_W-1:0]; sh_op = op_i; end
    endcase
  end

  always_comb begin
    ext_c = {{bit_width{1'b0}}, (ar_op == ADC || ar_op == SBB) & cin_i};
    case (ar_op)
      SUB, SBB: sum = {1'b0, ar_a} - {1'b0, ar_b} - ext_c;
      default:  sum = {1'b0, ar_a} + {1'b0, ar_b} + ext_c;
    endcase
    if (ar_op[0])
      ar_of = (ar_a[MSB] != ar_b[MSB]) && (sum[MSB] != ar_a[MSB]);
    else
      ar_of = (ar_a[MSB] == ar_b[MSB]) && (sum[MSB] != ar_a[MSB]);
  end

  always_comb begin
    case (lg_op)
      2'b00:   lg_r = lg_a & lg_b;
      2'b01:   lg_r = lg_a | lg_b;
      2'b10:   lg_r = lg_a ^ lg_b;
      default: lg_r = ~(lg_a | lg_b);
    endcase
  end

  // op[1] selects a fixed shift of one; op[0] selects rotate (left) or arithmetic (right).
  logic [SH_W-1:0] amt;
  assign amt   = sh_op[1] ? SH_W'(1) : sh_amt;
  assign shl_r = sh_op[0] ? ((sh_a << amt) | (sh_a >> (bit_width - int'(amt)))) : (sh_a << amt);
  assign shr_r = sh_op[0] ? $unsigned($signed(sh_a) >>> amt) : (sh_a >> amt);

  always_comb begin
    case (unit_i)
      ARITHMETIC: r_o = sum[bit_width-1:0];
      LOGIC:      r_o = lg_r;
      LSHIFT:     r_o = shl_r;
      default:    r_o = shr_r;
    endcase
    cf_o = (unit_i == ARITHMETIC) & sum[bit_width];
    of_o = (unit_i == ARITHMETIC) & ar_of;
    zf_o = (r_o == '0);
  end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - operand-stream issue/capture around the ALU; ALU_SEQ_CHAIN_EN enables multi-beat frames
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int bit_width = 4,
  parameter int words     = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [1:0]           IN_UNIT,
  input  logic [1:0]           IN_OP,
  input  logic [bit_width-1:0] IN_A,
  input  logic [bit_width-1:0] IN_B,
  input  logic                 IN_LAST,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [bit_width-1:0] OUT_R,
  output logic                 OUT_LAST,
  output logic                 OUT_CF,
  output logic                 OUT_OF,
  output logic                 OUT_ZF,
  output logic                 CF_Q
);

  alu_beat_t            beat_q, beat_d;
  logic                 out_valid_q, out_valid_d;
  logic                 cf_q, cf_d;
  logic                 accept, is_arith, beat_last, beat_zf;
  alu_submodule_e       alu_unit;
  logic [1:0]           alu_op;
  logic                 alu_cin, alu_cf, alu_of, alu_zf;
  logic [bit_width-1:0] alu_r;

  assign IN_READY = !RST && (!out_valid_q || OUT_READY);
  assign accept   = IN_VALID && IN_READY;

  ALU #(.bit_width(bit_width)) u_alu (
    .unit_i (alu_unit),
    .op_i   (alu_op),
    .a_i    (IN_A),
    .b_i    (IN_B),
    .cin_i  (alu_cin),
    .r_o    (alu_r),
    .cf_o   (alu_cf),
    .of_o   (alu_of),
    .zf_o   (alu_zf)
  );

`ifdef ALU_SEQ_CHAIN_EN
  localparam int CNT_W = $clog2(words) + 1;
  localparam logic [0:0] ST_FIRST = 1'b0;
  localparam logic [0:0] ST_CONT  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             chain_cf_q, chain_cf_d, zacc_q, zacc_d, in_first;
  alu_submodule_e   unit_q, unit_d;
  logic [1:0]       op_q, op_d;

  always_comb begin
    in_first = (state_q == ST_FIRST);
    alu_unit = in_first ? alu_submodule_e'(IN_UNIT) : unit_q;
    is_arith = (alu_unit == ARITHMETIC);
    alu_op   = in_first ? IN_OP : op_q;
    // Continuation beats always consume the carry chained from the previous word.
    if (!in_first && is_arith)
      alu_op[1] = 1'b1;
    alu_cin   = in_first ? cf_q : chain_cf_q;
    beat_last = IN_LAST || (cnt_q == CNT_W'(words - 1));
    beat_zf   = beat_last ? (zacc_q & alu_zf) : alu_zf;

    state_d = state_q; cnt_d = cnt_q; chain_cf_d = chain_cf_q; zacc_d = zacc_q;
    unit_d = unit_q; op_d = op_q; cf_d = cf_q;
    if (accept) begin
      chain_cf_d = alu_cf;
      if (in_first) begin
        unit_d = alu_unit;
        op_d   = IN_OP;
      end
      if (beat_last) begin
        state_d = ST_FIRST;
        cnt_d   = '0;
        zacc_d  = 1'b1;
        if (is_arith)
          cf_d = alu_cf;
      end else begin
        state_d = ST_CONT;
        cnt_d   = cnt_q + 1'b1;
        zacc_d  = zacc_q & alu_zf;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_FIRST; cnt_q <= '0; chain_cf_q <= 1'b0; zacc_q <= 1'b1;
      unit_q <= ARITHMETIC; op_q <= '0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; chain_cf_q <= chain_cf_d; zacc_q <= zacc_d;
      unit_q <= unit_d; op_q <= op_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = IN_LAST ^ (words > 1);

  always_comb begin
    alu_unit  = alu_submodule_e'(IN_UNIT);
    is_arith  = (alu_unit == ARITHMETIC);
    alu_op    = IN_OP;
    alu_cin   = cf_q;
    beat_last = 1'b1;
    beat_zf   = alu_zf;
    cf_d      = (accept && is_arith) ? alu_cf : cf_q;
  end
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    beat_d      = beat_q;
    if (accept) begin
      out_valid_d = 1'b1;
      beat_d.r    = ALU_W_MAX'(alu_r);
      beat_d.last = beat_last;
      beat_d.cf   = alu_cf;
      beat_d.of   = is_arith & alu_of;
      beat_d.zf   = beat_zf;
    end else if (OUT_READY) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid_q <= 1'b0;
      beat_q      <= '0;
      cf_q        <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      beat_q      <= beat_d;
      cf_q        <= cf_d;
    end
  end

  logic unused_r_hi;
  assign unused_r_hi = ^beat_q.r;

  assign OUT_VALID = out_valid_q;
  assign OUT_R     = beat_q.r[bit_width-1:0];
  assign OUT_LAST  = beat_q.last;
  assign OUT_CF    = beat_q.cf;
  assign OUT_OF    = beat_q.of;
  assign OUT_ZF    = beat_q.zf;
  assign CF_Q      = cf_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench for alu_sequencer against a behavioural model
module tb_alu_sequencer;

  localparam int BW = 4;
  localparam int WORDS = 2;
  localparam int MASK = 15;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          IN_VALID = 1'b0;
  logic          IN_READY;
  logic [1:0]    IN_UNIT = '0;
  logic [1:0]    IN_OP = '0;
  logic [BW-1:0] IN_A = '0;
  logic [BW-1:0] IN_B = '0;
  logic          IN_LAST = 1'b0;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b1;
  logic [BW-1:0] OUT_R;
  logic          OUT_LAST, OUT_CF, OUT_OF, OUT_ZF, CF_Q;

  alu_sequencer #(.bit_width(BW), .words(WORDS)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_UNIT(IN_UNIT), .IN_OP(IN_OP), .IN_A(IN_A), .IN_B(IN_B), .IN_LAST(IN_LAST),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_R(OUT_R), .OUT_LAST(OUT_LAST),
    .OUT_CF(OUT_CF), .OUT_OF(OUT_OF), .OUT_ZF(OUT_ZF), .CF_Q(CF_Q)
  );

  initial forever #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] r;
    logic       last;
    logic       cf;
    logic       of;
    logic       zf;
    logic       cfq;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   hold_cnt = 0;
  bit   rand_bp = 1'b0;

  // Model state: position within the open frame, its unit/op, carries and zero accumulator.
  int m_cnt = 0;
  int m_unit = 0;
  int m_op = 0;
  bit m_chain = 1'b0;
  bit m_zacc = 1'b1;
  bit m_cf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= 8) ? v - 16 : v;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_unit = 0; m_op = 0; m_chain = 1'b0; m_zacc = 1'b1; m_cf = 1'b0;
  endtask

  task automatic model_beat(input int unit, input int op, input int a, input int b,
                            input bit last_in, output exp_t e);
    int  u, o, c, s, ss, amt, r;
    bit  first, last, cf, of, zero;
`ifdef ALU_SEQ_CHAIN_EN
    first = (m_cnt == 0);
    u = first ? unit : m_unit;
    o = first ? op : m_op;
    if (!first && u == 0) o = o | 2;
    c = first ? int'(m_cf) : int'(m_chain);
    last = last_in || (m_cnt == WORDS - 1);
`else
    first = 1'b1;
    u = unit; o = op; c = int'(m_cf); last = 1'b1;
`endif
    cf = 1'b0; of = 1'b0; r = 0;
    amt = (o >= 2) ? 1 : (b % 4);
    case (u)
      0: begin
        if (o < 2) c = 0;
        if (o % 2 == 0) begin s = a + b + c; ss = sx(a) + sx(b) + c; cf = (s > MASK); end
        else begin s = a - b - c; ss = sx(a) - sx(b) - c; cf = (s < 0); end
        r = s & MASK;
        of = (ss > 7) || (ss < -8);
      end
      1: case (o)
        0: r = a & b;
        1: r = a | b;
        2: r = a ^ b;
        default: r = ~(a | b) & MASK;
      endcase
      2: r = (o % 2 == 1) ? (((a << amt) | (a >> (BW - amt))) & MASK) : ((a << amt) & MASK);
      default: r = (o % 2 == 1) ? ((sx(a) >>> amt) & MASK) : (a >> amt);
    endcase
    zero = (r == 0);
    e.r = r[3:0];
    e.last = last;
    e.cf = cf;
    e.of = of;
    e.zf = last ? (m_zacc && zero) : zero;
`ifdef ALU_SEQ_CHAIN_EN
    if (first) begin m_unit = unit; m_op = op; end
    m_chain = cf;
`endif
    if (last) begin
      if (u == 0) m_cf = cf;
      m_cnt = 0;
      m_zacc = 1'b1;
    end else begin
      m_cnt++;
      m_zacc = m_zacc && zero;
    end
    e.cfq = m_cf;
  endtask

  task automatic send_beat(input int unit, input int op, input int a, input int b, input bit last);
    exp_t e;
    int   waitc;
    bit   done;
    IN_VALID = 1'b1;
    IN_UNIT = unit[1:0]; IN_OP = op[1:0]; IN_A = a[3:0]; IN_B = b[3:0]; IN_LAST = last;
    waitc = 0; done = 1'b0;
    while (!done) begin
      @(negedge CLK);
      if (IN_READY) begin
        model_beat(unit, op, a, b, last, e);
        exp_q.push_back(e);
        done = 1'b1;
      end else if (++waitc > 100) begin
        check("accept_timeout", 32'd1, 32'd0);
        done = 1'b1;
      end
    end
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    RST = 1'b1;
    IN_VALID = 1'b0;
    exp_q.delete();
    model_reset();
    repeat (cycles) begin
      @(negedge CLK);
      check("in_ready_during_reset", {31'd0, IN_READY}, 32'd0);
      @(posedge CLK); #1;
    end
    RST = 1'b0;
    @(negedge CLK);
    check("reset_state", {OUT_VALID, OUT_R, OUT_LAST, OUT_CF, OUT_OF, OUT_ZF, CF_Q}, 32'd0);
    @(posedge CLK); #1;
  endtask

  initial begin
    OUT_READY = 1'b1;
    forever begin
      @(posedge CLK); #1;
      if (hold_cnt > 0) begin
        OUT_READY = 1'b0;
        hold_cnt--;
      end else begin
        OUT_READY = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  logic [9:0] held;
  bit         have_hold = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST) begin
        have_hold = 1'b0;
      end else begin
        if (have_hold)
          check("hold_stable", {OUT_VALID, OUT_R, OUT_LAST, OUT_CF, OUT_OF, OUT_ZF, CF_Q}, held);
        check("in_ready", {31'd0, IN_READY}, {31'd0, (!OUT_VALID || OUT_READY)});
        if (OUT_VALID && OUT_READY) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", {OUT_R, OUT_LAST, OUT_CF, OUT_OF, OUT_ZF, CF_Q}, 32'h1ff);
          end else begin
            e = exp_q.pop_front();
            check("beat", {OUT_R, OUT_LAST, OUT_CF, OUT_OF, OUT_ZF, CF_Q}, e);
          end
        end
        have_hold = OUT_VALID && !OUT_READY;
        held = {OUT_VALID, OUT_R, OUT_LAST, OUT_CF, OUT_OF, OUT_ZF, CF_Q};
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int waitc;
    @(posedge CLK); #1;
    do_reset(2);

    // Chained ADD across two words
    send_beat(0, 0, 15, 1, 1'b0);
    send_beat(0, 0, 0, 0, 1'b1);
    // ADC consuming the carry register
    send_beat(0, 0, 15, 1, 1'b1);
    send_beat(0, 2, 2, 3, 1'b1);
    // Zero flag accumulated over a LOGIC frame
    send_beat(1, 0, 3, 12, 1'b0);
    send_beat(1, 0, 15, 0, 1'b1);
    // Backpressure with a continuous input stream
    hold_cnt = 3;
    for (int i = 0; i < 4; i++) send_beat(0, 0, i, 2, 1'b1);
    // Frame force-closed after the maximum beat count
    send_beat(0, 0, 15, 1, 1'b0);
    send_beat(0, 0, 15, 0, 1'b0);
    send_beat(0, 0, 0, 0, 1'b0);
    send_beat(0, 0, 0, 0, 1'b1);
    // Reset in the middle of a frame
    send_beat(0, 0, 15, 1, 1'b0);
    do_reset(1);
    send_beat(0, 0, 0, 0, 1'b1);

    rand_bp = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0)
        do_reset(1);
      else
        send_beat($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15),
                  $urandom_range(0, 15), ($urandom_range(0, 2) == 0));
    end

    rand_bp = 1'b0;
    waitc = 0;
    while (exp_q.size() != 0 && waitc < 50) begin
      @(posedge CLK); #1;
      waitc++;
    end
    check("drain_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Issue/capture stage that drives the combinational ALU from a valid/ready operand stream and returns registered results with flags. Operands arrive as frames of 1..`words` beats, least-significant word first. Arithmetic carry is chained across the beats of a frame, so multi-word ADD/SUB/ADC/SBB run on the `bit_width` datapath. The block sits between the decode/operand-fetch logic and writeback, and holds the architectural carry flag.

## Interface
- `bit_width`, 4: word width; must be a power of two, ≥ 4.
- `words`, 2: maximum beats per frame, ≥ 1.

Ports:
- `CLK` in 1: clock.
- `RST` in 1: synchronous, active-high reset.
- `IN_VALID` in 1: operand beat valid.
- `IN_READY` out 1: beat accepted when `IN_VALID & IN_READY`.
- `IN_UNIT` in 2: submodule select, ALU_SUBMODULE encoding (ARITHMETIC=0, LOGIC=1, LSHIFT=2, RSHIFT=3).
- `IN_OP` in 2: submodule op code.
  - Arithmetic: 00 ADD, 01 SUB (A−B), 10 ADC, 11 SBB.
- `IN_A`, `IN_B` in `bit_width`: operands.
- `IN_LAST` in 1: final beat of frame.
- `OUT_VALID` out 1: result beat valid.
- `OUT_READY` in 1: result consumed when `OUT_VALID & OUT_READY`.
- `OUT_R` out `bit_width`: result word.
- `OUT_LAST` out 1: final beat of frame.
- `OUT_CF`, `OUT_OF` out 1: carry and overflow of this beat.
- `OUT_ZF` out 1: zero flag; frame-accumulated on the last beat.
- `CF_Q` out 1: architectural carry register.

## Operation
- **Internal ALU drive:** an internal ALU instance is driven from the current input beat. Unselected submodule slots get zero op/operands.
- **Frame FSM:** states FIRST and CONT.
  - FIRST: the accepted beat latches `IN_UNIT`/`IN_OP` as the frame's unit/op.
  - CONT: `IN_UNIT`/`IN_OP` are ignored; the latched values are used.
- **FSM transitions:**
  - FIRST→CONT on an accepted beat with `IN_LAST=0` and `words>1`.
  - CONT→FIRST on an accepted beat that is last.
  - A beat is last if `IN_LAST=1` or the beat counter reaches `words−1`.
- **Beat counter:** `$clog2(words)+1` bits. Cleared in FIRST, incremented per accepted beat.
- **Overflow:** a frame with no `IN_LAST` after `words` beats is force-closed. That beat gets `OUT_LAST=1`; the next beat starts a new frame.
- **Arithmetic carry, first beat:** ALU carry-in = `CF_Q`, ALU op = latched op. ADD/SUB therefore ignore `CF_Q` via op[1]=0.
- **Arithmetic carry, CONT beats:** ALU op[1] is forced to 1 and carry-in = `chain_cf`, the ALU CF of the previous beat. op[0] is kept.
- **Carry register:** `CF_Q` is updated to the ALU CF on the last beat of an ARITHMETIC frame only. LOGIC/shift frames leave it unchanged.
- **Non-arithmetic units:** LOGIC and shift units process each beat independently; there is no cross-word shift.
- **Zero flag:** `zacc` is ANDed over the ALU ZF of every beat in the frame.
  - LOGIC/shift units use `OUT_R==0` as the per-beat zero.
  - `OUT_ZF` = per-beat zero on non-last beats, `zacc & zero` on the last beat.
- **Overflow flag:** `OUT_OF` is the ALU OF for arithmetic beats and 0 otherwise.

## Timing
- Latency 1: a beat accepted at edge N produces `OUT_VALID=1` after edge N, with registered `OUT_*`.
- `IN_READY = !RST & (!OUT_VALID | OUT_READY)`.
  - Full throughput: 1 beat/cycle.
  - Simultaneous output drain and new accept in the same cycle is allowed.
- While `OUT_VALID & !OUT_READY`: all `OUT_*` are held stable and no beat is accepted.
- Reset values:
  - `OUT_VALID`, `OUT_R`, `OUT_LAST`, `OUT_CF`, `OUT_OF`, `OUT_ZF`, `CF_Q`, `chain_cf` = 0.
  - `zacc` = 1; counter = 0; state = FIRST.
- Reset mid-frame abandons the frame and any pending output beat. The next accepted beat is a first beat.

## Configuration
- `ALU_SEQ_CHAIN_EN` defined: frame chaining as above.
- `ALU_SEQ_CHAIN_EN` undefined:
  - Every beat is a single-beat frame; FSM, counter and `chain_cf` are removed.
  - `IN_LAST` is ignored and `OUT_LAST` is always 1.
  - Each beat uses its own `IN_UNIT`/`IN_OP`.
  - `CF_Q` is updated on every arithmetic beat.

## Structure
- Shared package `alu_pkg`:
  - ALU_SUBMODULE enum, moved there from file scope.
  - Arithmetic op-code constants ADD/SUB/ADC/SBB.
  - A packed struct for a result beat (r, last, cf, of, zf).
- One sub-module: the existing `ALU`, instantiated with `bit_width`.

## Test plan
All scenarios use `bit_width=4`, `words=2`.
- **Chained ADD:** ADD beats (A=0xF, B=0x1, LAST=0), (A=0x0, B=0x0, LAST=1) → `OUT_R` 0x0 (CF=1), then 0x1 (CF=0, ZF=0, LAST=1); `CF_Q`=0.
- **ADC from carry register:** with `CF_Q`=1, single-beat ADC A=0x2, B=0x3, LAST=1 → `OUT_R`=0x6, `CF_Q`=0.
- **Accumulated ZF:** LOGIC AND beats (0x3, 0xC), (0xF, 0x0, LAST) → both `OUT_R`=0; last beat `OUT_ZF`=1; `CF_Q` unchanged.
- **Backpressure:** hold `OUT_READY`=0 for 3 cycles with `IN_VALID`=1 → `IN_READY`=0, `OUT_R` stable, no beat dropped or duplicated.
- **Frame overflow:** 3 ADD beats with `IN_LAST`=0 → beat 2 gets `OUT_LAST`=1; beat 3 uses `CF_Q` as carry-in, not the chained carry.
- **Reset mid-frame:** ADD beat A=0xF, B=0x1 (CF=1), then RST for 1 cycle → `OUT_VALID`=0, `CF_Q`=0; next ADD beat 0x0+0x0 gives 0x0, not 0x1.
